mem_port_arbiter: RTL

Shares one external single-port memory bus between the core's instruction-fetch port and its data (load/store) port. It sits between the core's instruction/data interfaces and the memory. It sequences one bus transaction at a time through a req/ack handshake. It drives a pipeline stall while any request is outstanding, and it bounds bus latency with a timeout.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory bus between the fetch and load/store ports
// One transaction in flight at a time; each grant is followed by BUSY until ack or timeout.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter int MAX_STREAK = 4
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_instr_req,
    input  logic [AW-1:0] i_instr_addr,
    output logic [DW-1:0] o_instr_rdata,
    output logic          o_instr_valid,
    input  logic          i_data_rd,
    input  logic          i_data_wr,
    input  logic [AW-1:0] i_data_addr,
    input  logic [DW-1:0] i_data_wdata,
    output logic [DW-1:0] o_data_rdata,
    output logic          o_data_valid,
    output logic          o_stall,
    output logic          o_bus_req,
    output logic          o_bus_we,
    output logic [AW-1:0] o_bus_addr,
    output logic [DW-1:0] o_bus_wdata,
    input  logic          i_bus_ack,
    input  logic [DW-1:0] i_bus_rdata,
    output logic          o_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        r_state;
    logic [TW-1:0] r_tmo_cnt;
    logic [SW-1:0] r_streak;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata;
    logic [DW-1:0] r_instr_rdata;
    logic          r_instr_valid;
    logic [DW-1:0] r_data_rdata;
    logic          r_data_valid;
    logic          r_err;

    logic w_data_req;
    logic w_data_ok;
    logic w_instr_ok;
    logic w_streak_max;
    logic w_grant_i;
    logic w_grant_d;
    logic w_tmo;
    logic w_done;

    // A port whose valid is high this cycle is still presenting the request that just completed.
    assign w_data_req   = i_data_rd | i_data_wr;
    assign w_data_ok    = w_data_req & ~r_data_valid;
    assign w_instr_ok   = i_instr_req & ~r_instr_valid;
    assign w_streak_max = (r_streak == SW'(MAX_STREAK));
    assign w_grant_i    = w_instr_ok & (~w_data_ok | w_streak_max);
    assign w_grant_d    = w_data_ok & ~w_grant_i;
    assign w_tmo        = (r_tmo_cnt == TW'(TIMEOUT - 1));
    assign w_done       = i_bus_ack | w_tmo;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state       <= IDLE;
            r_tmo_cnt     <= '0;
            r_streak      <= '0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_instr_rdata <= '0;
            r_instr_valid <= 1'b0;
            r_data_rdata  <= '0;
            r_data_valid  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            r_data_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tmo_cnt <= '0;
                    if (w_grant_i) begin
                        r_state     <= BUSY_I;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= i_instr_addr;
                        r_bus_wdata <= '0;
                        r_streak    <= '0;
                    end else if (w_grant_d) begin
                        r_state     <= BUSY_D;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_data_wr;
                        r_bus_addr  <= i_data_addr;
                        r_bus_wdata <= i_data_wdata;
                        if (!i_instr_req) begin
                            r_streak <= '0;
                        end else if (!w_streak_max) begin
                            r_streak <= r_streak + SW'(1);
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_bus_req <= 1'b0;
                        r_tmo_cnt <= '0;
                        // Ack on the final allowed cycle counts as a normal completion.
                        if (!i_bus_ack) begin
                            r_err <= 1'b1;
                        end
                        if (r_state == BUSY_I) begin
                            r_instr_valid <= 1'b1;
                            r_instr_rdata <= i_bus_ack ? i_bus_rdata : '0;
                        end else begin
                            r_data_valid <= 1'b1;
                            if (!r_bus_we) begin
                                r_data_rdata <= i_bus_ack ? i_bus_rdata : '0;
                            end
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_stall       = (w_data_req & ~r_data_valid) | (i_instr_req & ~r_instr_valid);
    assign o_bus_req     = r_bus_req;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_instr_rdata = r_instr_rdata;
    assign o_instr_valid = r_instr_valid;
    assign o_data_rdata  = r_data_rdata;
    assign o_data_valid  = r_data_valid;
    assign o_err         = r_err;

endmodule
